// File: rtl/seq_mult_hs.sv
// Sequential shift-and-add multiplier, W x W -> 2W, with valid/ready handshakes,
// per-transaction signed mode, optional early exit and output backpressure.
module seq_mult_hs #(
    parameter int W          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  LAST_C = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_a_sh;
    logic [2*W-1:0]    r_b_sh;
    logic [2*W-1:0]    r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;
    logic              r_out_valid;
    logic [2*W-1:0]    r_product;

    logic              w_accept;
    logic              w_early;
    logic              w_last;

    // Magnitude of an operand; the most negative value maps onto 2^(W-1),
    // which still fits in W unsigned bits.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic is_signed);
        logic signed [W-1:0] sx;
        sx = signed'(x);
        if (is_signed && (sx < 0))
            return ~x + ONE_W;
        return x;
    endfunction

    function automatic logic [2*W-1:0] apply_sign(input logic [2*W-1:0] x, input logic neg);
        return neg ? (~x + ONE_2W) : x;
    endfunction

    // in_ready is forced low during reset so nothing is accepted while held.
    assign in_ready  = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign w_early   = EARLY_EXIT && (r_a_sh == '0);
    assign w_last    = (r_cnt == LAST_C);
    assign out_valid = r_out_valid;
    assign product   = r_product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_CALC;
            S_CALC:   if (w_early || w_last) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready)
                    w_state_nxt = w_accept ? S_CALC : S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load on accept, one shift/add step per CALC edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= magnitude(a, signed_mode);
            r_b_sh <= {{W{1'b0}}, magnitude(b, signed_mode)};
            r_acc  <= '0;
            r_cnt  <= '0;
            r_neg  <= signed_mode && (a[W-1] ^ b[W-1]);
        end else if ((r_state == S_CALC) && !w_early) begin
            if (r_a_sh[0])
                r_acc <= r_acc + r_b_sh;
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh << 1;
            r_cnt  <= r_cnt + ONE_C;
        end
    end

    // Result register only moves in FINISH and is held across the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else if (r_state == S_FINISH) begin
            r_out_valid <= 1'b1;
            r_product   <= apply_sign(r_acc, r_neg);
        end else if ((r_state == S_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs: directed cases, backpressure, back-to-back,
// reset abort and a randomized sweep against an arithmetic reference model.
module tb_seq_mult_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid [3];
    logic        out_ready[3];
    logic        sm       [3];
    logic        in_ready [3];
    logic        out_valid[3];
    logic [12:0] a_v      [3];
    logic [12:0] b_v      [3];
    logic [15:0] p8e, p8f;
    logic [25:0] p13;
    logic [25:0] prod_c   [3];

    int n_checks = 0;
    int n_fail   = 0;
    int accepts[3];
    int results[3];

    assign prod_c[0] = {10'd0, p8e};
    assign prod_c[1] = {10'd0, p8f};
    assign prod_c[2] = p13;

    always #5 clk = ~clk;

    // Instance 0: W=8 early exit, 1: W=8 full iterations, 2: W=13 early exit.
    seq_mult_hs #(.W(8), .EARLY_EXIT(1'b1)) dut8e (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .signed_mode(sm[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(p8e));

    seq_mult_hs #(.W(8), .EARLY_EXIT(1'b0)) dut8f (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .signed_mode(sm[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(p8f));

    seq_mult_hs #(.W(13), .EARLY_EXIT(1'b1)) dut13 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .signed_mode(sm[2]), .a(a_v[2]), .b(b_v[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .product(p13));

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (in_valid[i] && in_ready[i])   accepts[i] <= accepts[i] + 1;
            if (out_valid[i] && out_ready[i]) results[i] <= results[i] + 1;
        end
    end

    function automatic longint ref_prod(longint av, longint bv, bit s, int w);
        longint x, y;
        x = av;
        y = bv;
        if (s) begin
            if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
            if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
        end
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    function automatic int ref_lat(longint av, bit s, int w, bit ee);
        longint mag;
        int     m;
        if (!ee) return w + 1;
        mag = (s && av >= (longint'(1) << (w - 1))) ? (longint'(1) << w) - av : av;
        if (mag == 0) return 2;
        m = 0;
        for (int i = 0; i <= w; i++)
            if (((mag >> i) & 1) == 1) m = i;
        return (m + 3 < w + 1) ? m + 3 : w + 1;
    endfunction

    // Wait for out_valid after an accept edge; returns the number of edges taken.
    task automatic wait_result(input int idx, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid[idx] && lat < 40);
    endtask

    task automatic run_txn(input int idx, input longint av, input longint bv, input bit s,
                           input int stall, input longint exp_p, input int exp_lat);
        int          t;
        int          lat;
        bit          ok;
        logic [25:0] ep;
        ep = exp_p[25:0];
        @(negedge clk);
        a_v[idx] = av[12:0];
        b_v[idx] = bv[12:0];
        sm[idx] = s;
        in_valid[idx] = 1'b1;
        out_ready[idx] = 1'b0;
        t = 0;
        while (!in_ready[idx] && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!in_ready[idx]) begin
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready=%b required 1", idx, in_ready[idx]);
        end
        @(posedge clk);
        #1 in_valid[idx] = 1'b0;
        wait_result(idx, lat);
        n_checks++;
        if (out_valid[idx] !== 1'b1 || lat != exp_lat) begin
            n_fail++;
            $display("FAIL latency dut%0d a=%0d b=%0d s=%0d: got %0d (valid=%b) required %0d",
                     idx, av, bv, s, lat, out_valid[idx], exp_lat);
        end
        n_checks++;
        if (prod_c[idx] !== ep) begin
            n_fail++;
            $display("FAIL product dut%0d a=%0d b=%0d s=%0d: got 0x%0h required 0x%0h",
                     idx, av, bv, s, prod_c[idx], ep);
        end
        ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (out_valid[idx] !== 1'b1 || prod_c[idx] !== ep || in_ready[idx] !== 1'b0) ok = 1'b0;
        end
        if (stall > 0) begin
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL stall_hold dut%0d: valid=%b prod=0x%0h in_ready=%b required 1/0x%0h/0",
                         idx, out_valid[idx], prod_c[idx], in_ready[idx], ep);
            end
        end
        @(negedge clk);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        n_checks++;
        if (out_valid[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL consume dut%0d: out_valid=%b required 0", idx, out_valid[idx]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || prod_c[i] !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b prod=0x%0h required 0/0/0",
                         i, in_ready[i], out_valid[i], prod_c[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_reset dut%0d: in_ready=%b required 1", i, in_ready[i]);
            end
        end
    endtask

    task automatic test_directed();
        run_txn(0, 255, 255, 1'b0, 0, 64'hFE01, 9);
        run_txn(0, 128, 128, 1'b1, 1, 64'h4000, 9);
        run_txn(0, 253, 5,   1'b1, 2, 64'hFFF1, 4);
        run_txn(0, 0,   77,  1'b0, 0, 0,        2);
        run_txn(0, 3,   200, 1'b0, 0, 64'h0258, 4);
        run_txn(1, 0,   77,  1'b0, 0, 0,        9);
        run_txn(1, 3,   200, 1'b0, 0, 64'h0258, 9);
        run_txn(2, 8191, 8191, 1'b0, 0, 64'h3FFC001, 14);
        run_txn(2, 4096, 4096, 1'b1, 0, 64'h1000000, 14);
    endtask

    task automatic test_back_to_back();
        int  lat;
        int  edges;
        int  got;
        int  last;
        bit  ok;
        @(negedge clk);
        a_v[0] = 13'd5; b_v[0] = 13'd7; sm[0] = 1'b0;
        in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        wait_result(0, lat);
        n_checks++;
        if (lat != 5 || prod_c[0] !== 26'd35) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d prod=%0d required 5/35", lat, prod_c[0]);
        end
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b1 || prod_c[0] !== 26'd35 || in_ready[0] !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL backpressure_hold: valid=%b prod=%0d in_ready=%b required 1/35/0",
                     out_valid[0], prod_c[0], in_ready[0]);
        end
        @(negedge clk);
        a_v[0] = 13'd2; b_v[0] = 13'd3; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_on_consume: in_ready=%b required 1", in_ready[0]);
        end
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        n_checks++;
        if (out_valid[0] !== 1'b0 || prod_c[0] !== 26'd35) begin
            n_fail++;
            $display("FAIL same_edge_consume: valid=%b prod=%0d required 0/35", out_valid[0], prod_c[0]);
        end
        wait_result(0, lat);
        n_checks++;
        if (lat != 4 || prod_c[0] !== 26'd6) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d prod=%0d required 4/6", lat, prod_c[0]);
        end
        // Streaming with both sides always ready: one result per latency+1 edges.
        @(negedge clk);
        a_v[0] = 13'd3; b_v[0] = 13'd11; sm[0] = 1'b1;
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        edges = 0; got = 0; last = 0;
        while (got < 4 && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (out_valid[0]) begin
                n_checks++;
                if (prod_c[0] !== 26'd33 || (got > 0 && edges - last != 5)) begin
                    n_fail++;
                    $display("FAIL stream_result %0d: prod=%0d spacing=%0d required 33/5",
                             got, prod_c[0], edges - last);
                end
                last = edges;
                got++;
                if (got == 4) in_valid[0] = 1'b0;
            end
        end
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL stream_count: got %0d results required 4", got);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        sm[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        a_v[0] = 13'd255; b_v[0] = 13'd255; sm[0] = 1'b0;
        in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || prod_c[0] !== 26'd0 || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b prod=%0d in_ready=%b required 0/0/0",
                     out_valid[0], prod_c[0], in_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL aborted_result: out_valid=%b required 0", out_valid[0]);
        end
        run_txn(0, 7, 9, 1'b0, 0, 63, 5);
    endtask

    task automatic test_random(input int idx, input int w, input bit ee, input int n);
        longint mask;
        longint av, bv;
        bit     s;
        int     r;
        mask = (longint'(1) << w) - 1;
        for (int k = 0; k < n; k++) begin
            av = longint'($urandom) & mask;
            bv = longint'($urandom) & mask;
            s  = $urandom_range(0, 1);
            r  = $urandom_range(0, 7);
            if (r == 0) av = 0;
            if (r == 1) begin av = longint'(1) << (w - 1); bv = av; end
            if (r == 2) begin av = mask; bv = mask; end
            if (r == 3) av = longint'(1) << $urandom_range(0, w - 1);
            run_txn(idx, av, bv, s, $urandom_range(0, 3),
                    ref_prod(av, bv, s, w), ref_lat(av, s, w, ee));
        end
    endtask

    task automatic test_result_count();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (results[i] != accepts[i] - ((i == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL result_count dut%0d: results=%0d accepts=%0d", i, results[i], accepts[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b0;
            sm[i] = 1'b0;
            a_v[i] = '0;
            b_v[i] = '0;
            accepts[i] = 0;
            results[i] = 0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 8, 1'b1, 1200);
        test_random(1, 8, 1'b0, 300);
        test_random(2, 13, 1'b1, 600);
        repeat (2) @(negedge clk);
        test_result_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
